// File: rtl/morse_symbol_decoder_if.sv
`default_nettype none
// ============================================================================
// Module      : morse_symbol_decoder_if
// Description : Decoded-character output stream (valid/ready, 8-bit ASCII).
// Revision    : 1.0 - initial release
// ============================================================================
interface morse_symbol_decoder_if;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_ready;

    modport master (output out_data, output out_valid, input out_ready);
    modport slave  (input out_data, input out_valid, output out_ready);
endinterface
`default_nettype wire

// File: rtl/morse_symbol_decoder.sv
`default_nettype none
// ============================================================================
// Module      : morse_symbol_decoder
// Description : Assembles dot/dash symbols into characters, emits ASCII.
// Revision    : 1.0 - initial release
// ============================================================================
module morse_symbol_decoder #(
    parameter bit         LOWERCASE    = 1'b0,
    parameter logic [7:0] UNKNOWN_CHAR = 8'h3F
) (
    input  wire logic                  clk,
    input  wire logic                  rst,
    input  wire logic [2:0]            sym_in,
    morse_symbol_decoder_if.master     out_if,
    output logic                       overrun,
    input  wire logic                  clr_err,
    output logic [2:0]                 elem_cnt
);
    localparam logic [2:0] c_SYM_DOT   = 3'b001;
    localparam logic [2:0] c_SYM_DASH  = 3'b010;
    localparam logic [2:0] c_SYM_CHAR  = 3'b011;
    localparam logic [2:0] c_SYM_WORD  = 3'b100;
    localparam logic [2:0] c_MAX_ELEM  = 3'd5;
    localparam logic [7:0] c_SPACE     = 8'h20;
    localparam logic [7:0] c_ALPHA     = LOWERCASE ? 8'h61 : 8'h41;

    logic [4:0] r_pattern;
    logic       r_too_long;
    logic       r_pending_space;
    logic       r_last_was_space;

    logic       w_hit;
    logic       w_alpha;
    logic [4:0] w_ofs;
    logic [3:0] w_dig;
    logic [7:0] w_char;

    // Unused upper pattern bits are always zero, so the full 8-bit key is exact.
    always_comb begin
        w_hit   = 1'b1;
        w_alpha = 1'b1;
        w_ofs   = 5'd0;
        w_dig   = 4'd0;
        case ({elem_cnt, r_pattern})
            {3'd2, 5'b00001}: w_ofs = 5'd0;
            {3'd4, 5'b01000}: w_ofs = 5'd1;
            {3'd4, 5'b01010}: w_ofs = 5'd2;
            {3'd3, 5'b00100}: w_ofs = 5'd3;
            {3'd1, 5'b00000}: w_ofs = 5'd4;
            {3'd4, 5'b00010}: w_ofs = 5'd5;
            {3'd3, 5'b00110}: w_ofs = 5'd6;
            {3'd4, 5'b00000}: w_ofs = 5'd7;
            {3'd2, 5'b00000}: w_ofs = 5'd8;
            {3'd4, 5'b00111}: w_ofs = 5'd9;
            {3'd3, 5'b00101}: w_ofs = 5'd10;
            {3'd4, 5'b00100}: w_ofs = 5'd11;
            {3'd2, 5'b00011}: w_ofs = 5'd12;
            {3'd2, 5'b00010}: w_ofs = 5'd13;
            {3'd3, 5'b00111}: w_ofs = 5'd14;
            {3'd4, 5'b00110}: w_ofs = 5'd15;
            {3'd4, 5'b01101}: w_ofs = 5'd16;
            {3'd3, 5'b00010}: w_ofs = 5'd17;
            {3'd3, 5'b00000}: w_ofs = 5'd18;
            {3'd1, 5'b00001}: w_ofs = 5'd19;
            {3'd3, 5'b00001}: w_ofs = 5'd20;
            {3'd4, 5'b00001}: w_ofs = 5'd21;
            {3'd3, 5'b00011}: w_ofs = 5'd22;
            {3'd4, 5'b01001}: w_ofs = 5'd23;
            {3'd4, 5'b01011}: w_ofs = 5'd24;
            {3'd4, 5'b01100}: w_ofs = 5'd25;
            {3'd5, 5'b11111}: begin w_alpha = 1'b0; w_dig = 4'd0; end
            {3'd5, 5'b01111}: begin w_alpha = 1'b0; w_dig = 4'd1; end
            {3'd5, 5'b00111}: begin w_alpha = 1'b0; w_dig = 4'd2; end
            {3'd5, 5'b00011}: begin w_alpha = 1'b0; w_dig = 4'd3; end
            {3'd5, 5'b00001}: begin w_alpha = 1'b0; w_dig = 4'd4; end
            {3'd5, 5'b00000}: begin w_alpha = 1'b0; w_dig = 4'd5; end
            {3'd5, 5'b10000}: begin w_alpha = 1'b0; w_dig = 4'd6; end
            {3'd5, 5'b11000}: begin w_alpha = 1'b0; w_dig = 4'd7; end
            {3'd5, 5'b11100}: begin w_alpha = 1'b0; w_dig = 4'd8; end
            {3'd5, 5'b11110}: begin w_alpha = 1'b0; w_dig = 4'd9; end
            default:          w_hit = 1'b0;
        endcase
        if (!w_hit || r_too_long)
            w_char = UNKNOWN_CHAR;
        else if (w_alpha)
            w_char = c_ALPHA + {3'b000, w_ofs};
        else
            w_char = 8'h30 + {4'h0, w_dig};
    end

    logic w_elem;
    logic w_word;
    logic w_term;
    logic w_space_req;
    logic w_free;
    logic w_load_ok;
    logic w_ovr;

    assign w_elem      = (sym_in == c_SYM_DOT) || (sym_in == c_SYM_DASH);
    assign w_word      = (sym_in == c_SYM_WORD);
    assign w_term      = ((sym_in == c_SYM_CHAR) || w_word) && (elem_cnt != 3'd0);
    // A space already emitted or queued makes a bare word space redundant.
    assign w_space_req = w_word && (elem_cnt == 3'd0) && !r_last_was_space && !r_pending_space;
    assign w_free      = !out_if.out_valid || out_if.out_ready;
    assign w_load_ok   = w_free && !r_pending_space;
    assign w_ovr       = (w_term || w_space_req) && !w_load_ok;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_pattern        <= 5'd0;
            elem_cnt         <= 3'd0;
            r_too_long       <= 1'b0;
            r_pending_space  <= 1'b0;
            r_last_was_space <= 1'b1;
            out_if.out_data  <= 8'h00;
            out_if.out_valid <= 1'b0;
            overrun          <= 1'b0;
        end else begin
            if (out_if.out_valid && out_if.out_ready)
                out_if.out_valid <= 1'b0;

            if (r_pending_space && w_free) begin
                out_if.out_data  <= c_SPACE;
                out_if.out_valid <= 1'b1;
                r_pending_space  <= 1'b0;
                r_last_was_space <= 1'b1;
            end

            if (w_elem) begin
                r_pattern <= {r_pattern[3:0], sym_in[1]};
                if (elem_cnt == c_MAX_ELEM)
                    r_too_long <= 1'b1;
                else
                    elem_cnt <= elem_cnt + 3'd1;
            end

            if (w_term) begin
                r_pattern  <= 5'd0;
                elem_cnt   <= 3'd0;
                r_too_long <= 1'b0;
                if (w_load_ok) begin
                    out_if.out_data  <= w_char;
                    out_if.out_valid <= 1'b1;
                    r_last_was_space <= 1'b0;
                    if (w_word)
                        r_pending_space <= 1'b1;
                end
            end else if (w_space_req && w_load_ok) begin
                out_if.out_data  <= c_SPACE;
                out_if.out_valid <= 1'b1;
                r_last_was_space <= 1'b1;
            end

            if (w_ovr)
                overrun <= 1'b1;
            else if (clr_err)
                overrun <= 1'b0;
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_morse_symbol_decoder.sv
`default_nettype none
// ============================================================================
// Module      : tb_morse_symbol_decoder
// Description : Directed and random checks of two decoder instances
//               (uppercase / lowercase) against a string-table model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_morse_symbol_decoder;
    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [2:0] sym_in = 3'd0;
    logic       clr_err = 1'b0;
    logic       overrun0, overrun1;
    logic [2:0] elem_cnt0, elem_cnt1;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    morse_symbol_decoder_if u_if0 ();
    morse_symbol_decoder_if u_if1 ();

    morse_symbol_decoder #(.LOWERCASE(1'b0), .UNKNOWN_CHAR(8'h3F)) u_dut0 (
        .clk(clk), .rst(rst), .sym_in(sym_in), .out_if(u_if0),
        .overrun(overrun0), .clr_err(clr_err), .elem_cnt(elem_cnt0));

    morse_symbol_decoder #(.LOWERCASE(1'b1), .UNKNOWN_CHAR(8'h2A)) u_dut1 (
        .clk(clk), .rst(rst), .sym_in(sym_in), .out_if(u_if1),
        .overrun(overrun1), .clr_err(clr_err), .elem_cnt(elem_cnt1));

    // Letters A-Z followed by digits 0-9
    string codes [36] = '{".-", "-...", "-.-.", "-..", ".", "..-.", "--.", "....", "..",
                          ".---", "-.-", ".-..", "--", "-.", "---", ".--.", "--.-", ".-.",
                          "...", "-", "..-", "...-", ".--", "-..-", "-.--", "--..",
                          "-----", ".----", "..---", "...--", "....-", ".....",
                          "-....", "--...", "---..", "----."};

    // Behavioural model state
    string      cur;
    bit         m_valid, m_pend, m_lastsp, m_ovr;
    logic [7:0] m_data0, m_data1;

    function automatic logic [7:0] decode(input string p, input bit lc, input logic [7:0] unk);
        if (p.len() > 5) return unk;
        for (int i = 0; i < 36; i++) begin
            if (codes[i] == p) begin
                if (i < 26) return 8'((lc ? 97 : 65) + i);
                return 8'(48 + i - 26);
            end
        end
        return unk;
    endfunction

    task automatic model_reset();
        cur = ""; m_valid = 0; m_pend = 0; m_lastsp = 1; m_ovr = 0;
        m_data0 = 8'h00; m_data1 = 8'h00;
    endtask

    task automatic model_step(input logic [2:0] s, input bit rdy, input bit clr);
        bit free, ok, pend0, last0, ev;
        free  = !m_valid || rdy;
        pend0 = m_pend;
        last0 = m_lastsp;
        ok    = free && !pend0;
        ev    = 0;
        if (m_valid && rdy) m_valid = 0;
        if (pend0 && free) begin
            m_data0 = 8'h20; m_data1 = 8'h20; m_valid = 1; m_pend = 0; m_lastsp = 1;
        end
        if (s == 3'd1) cur = {cur, "."};
        else if (s == 3'd2) cur = {cur, "-"};
        else if ((s == 3'd3 || s == 3'd4) && cur.len() > 0) begin
            if (ok) begin
                m_data0 = decode(cur, 0, 8'h3F);
                m_data1 = decode(cur, 1, 8'h2A);
                m_valid = 1; m_lastsp = 0;
                if (s == 3'd4) m_pend = 1;
            end else ev = 1;
            cur = "";
        end else if (s == 3'd4 && !last0 && !pend0) begin
            if (ok) begin
                m_data0 = 8'h20; m_data1 = 8'h20; m_valid = 1; m_lastsp = 1;
            end else ev = 1;
        end
        if (ev) m_ovr = 1;
        else if (clr) m_ovr = 0;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_model();
        logic [7:0] ec;
        ec = 8'((cur.len() > 5) ? 5 : cur.len());
        chk("valid0",   {7'd0, u_if0.out_valid}, {7'd0, m_valid});
        chk("data0",    u_if0.out_data, m_data0);
        chk("overrun0", {7'd0, overrun0}, {7'd0, m_ovr});
        chk("elem0",    {5'd0, elem_cnt0}, ec);
        chk("valid1",   {7'd0, u_if1.out_valid}, {7'd0, m_valid});
        chk("data1",    u_if1.out_data, m_data1);
        chk("overrun1", {7'd0, overrun1}, {7'd0, m_ovr});
        chk("elem1",    {5'd0, elem_cnt1}, ec);
    endtask

    task automatic step(input logic [2:0] s, input bit rdy = 1'b1, input bit clr = 1'b0);
        sym_in = s; u_if0.out_ready = rdy; u_if1.out_ready = rdy; clr_err = clr;
        @(posedge clk);
        model_step(s, rdy, clr);
        #1;
        check_model();
    endtask

    task automatic do_reset();
        sym_in = 3'd0; clr_err = 1'b0;
        rst = 1'b0;
        #1;
        model_reset();
        check_model();
        @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    initial begin
        u_if0.out_ready = 1'b1;
        u_if1.out_ready = 1'b1;
        #2;
        do_reset();
        chk("rst_data", u_if0.out_data, 8'h00);

        // Test 1: .- -> 'A'
        step(3'd1); step(3'd0); step(3'd2); step(3'd0); step(3'd3);
        chk("t1_valid", {7'd0, u_if0.out_valid}, 8'd1);
        chk("t1_data",  u_if0.out_data, 8'h41);
        chk("t1_elem",  {5'd0, elem_cnt0}, 8'd0);
        step(3'd0);
        chk("t1_pulse", {7'd0, u_if0.out_valid}, 8'd0);

        // Test 2: -... + word space -> 'B', ' '; another word space silent
        step(3'd2); step(3'd1); step(3'd1); step(3'd1); step(3'd4);
        chk("t2_b", u_if0.out_data, 8'h42);
        step(3'd0);
        chk("t2_sp", u_if0.out_data, 8'h20);
        chk("t2_sp_valid", {7'd0, u_if0.out_valid}, 8'd1);
        step(3'd4);
        chk("t2_no_sp", {7'd0, u_if0.out_valid}, 8'd0);

        // Test 3: over-length and all-dash
        repeat (6) step(3'd1);
        step(3'd3);
        chk("t3_unk0", u_if0.out_data, 8'h3F);
        chk("t3_unk1", u_if1.out_data, 8'h2A);
        chk("t3_ovr",  {7'd0, overrun0}, 8'd0);
        step(3'd0);
        repeat (5) step(3'd2);
        step(3'd3);
        chk("t3_zero", u_if0.out_data, 8'h30);
        step(3'd0);

        // Test 4: no leading space, single space between words
        do_reset();
        step(3'd4);
        chk("t4_lead", {7'd0, u_if0.out_valid}, 8'd0);
        step(3'd1); step(3'd3);
        chk("t4_e", u_if0.out_data, 8'h45);
        step(3'd4);
        chk("t4_sp", u_if0.out_data, 8'h20);
        step(3'd4);
        chk("t4_one_sp", {7'd0, u_if0.out_valid}, 8'd0);
        step(3'd0);

        // Test 5: backpressure overrun, clear
        step(3'd1, 0); step(3'd3, 0);
        step(3'd2, 0); step(3'd3, 0);
        chk("t5_hold", u_if0.out_data, 8'h45);
        chk("t5_ovr",  {7'd0, overrun0}, 8'd1);
        step(3'd0, 1);
        step(3'd0, 1);
        chk("t5_drain", {7'd0, u_if0.out_valid}, 8'd0);
        step(3'd0, 1, 1);
        chk("t5_clr", {7'd0, overrun0}, 8'd0);

        // Test 6: reset mid-character
        step(3'd1); step(3'd2);
        do_reset();
        chk("t6_elem", {5'd0, elem_cnt0}, 8'd0);
        step(3'd1); step(3'd3);
        chk("t6_e",  u_if0.out_data, 8'h45);
        chk("t6_lc", u_if1.out_data, 8'h65);
        step(3'd0);

        // Random phase
        for (int n = 0; n < 4000; n++) begin
            int r;
            logic [2:0] s;
            bit rdy, clr;
            r = $urandom_range(0, 9);
            case (r)
                0, 1, 2: s = 3'd1;
                3, 4, 5: s = 3'd2;
                6:       s = 3'd3;
                7:       s = 3'd4;
                8:       s = 3'd0;
                default: s = 3'($urandom_range(5, 7));
            endcase
            rdy = ($urandom_range(0, 3) != 0);
            clr = ($urandom_range(0, 19) == 0);
            if ($urandom_range(0, 499) == 0) do_reset();
            else step(s, rdy, clr);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
